// File: rtl/accum_check_mon.sv
// accum_check_mon: downstream checker for the protected accumulator block.
//
// Keeps a shadow copy of the accumulator register and compares both
// accumulator outputs against it for NUM_CYCLES cycles after a start pulse.
// The result is a pass/fail verdict and a saturating count of error cycles.
//
// Ports:
//   clk              sole clock, posedge
//   rst              asynchronous active-high reset
//   start            one-cycle pulse, begins a run from IDLE or DONE
//   accum_in         value driven into the accumulator this cycle
//   accum_bypass     bypass select driven into the accumulator
//   accum_out        accumulator registered output
//   accum_bypass_out accumulator mixed comb/seq output
//   busy             high while a run is in progress
//   done             high once a run has completed
//   pass             high in DONE when the run saw no error cycles
//   err_count        error cycles in the current/last run (saturating)
//   cycle_cnt        checked cycles elapsed in the current run
//
// Optional feature, enabled by defining ACCUM_CHECK_MON_FIRST_ERR_EN:
//   first_err_cycle  cycle_cnt of the first error cycle in the run
//   first_err_data   accum_out sampled in that cycle
module accum_check_mon #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_CYCLES = 16,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] accum_in,
    input  logic             accum_bypass,
    input  logic [WIDTH-1:0] accum_out,
    input  logic [WIDTH-1:0] accum_bypass_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      cycle_cnt
`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
    ,
    output logic [15:0]      first_err_cycle,
    output logic [WIDTH-1:0] first_err_data
`endif
);

    localparam logic [ERR_W-1:0] ErrMax    = {ERR_W{1'b1}};
    localparam logic [15:0]      LastCycle = 16'(NUM_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [15:0]      cyc_q, cyc_d;
    logic             pass_q, pass_d;

    logic seq_ok, mix_ok, cycle_err;

    assign seq_ok = (accum_out == shadow_q);
    assign mix_ok = (accum_bypass_out == (accum_bypass ? accum_in : shadow_q));

`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
    logic             fe_seen_q, fe_seen_d;
    logic [15:0]      fe_cycle_q, fe_cycle_d;
    logic [WIDTH-1:0] fe_data_q, fe_data_d;
`endif

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        err_d     = err_q;
        cyc_d     = cyc_q;
        pass_d    = pass_q;
        cycle_err = 1'b0;
`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
        fe_seen_d  = fe_seen_q;
        fe_cycle_d = fe_cycle_q;
        fe_data_d  = fe_data_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StRun;
                    // The accumulator register has no reset, so resync to
                    // whatever value it will hold after this edge.
                    shadow_d = accum_out + accum_in;
                    err_d    = '0;
                    cyc_d    = '0;
                    pass_d   = 1'b0;
`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
                    fe_seen_d  = 1'b0;
                    fe_cycle_d = '0;
                    fe_data_d  = '0;
`endif
                end
            end
            StRun: begin
                cycle_err = !(seq_ok && mix_ok);
                if (cycle_err && (err_q != ErrMax)) begin
                    err_d = err_q + 1'b1;
                end
`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
                if (cycle_err && !fe_seen_q) begin
                    fe_seen_d  = 1'b1;
                    fe_cycle_d = cyc_q;
                    fe_data_d  = accum_out;
                end
`endif
                shadow_d = shadow_q + accum_in;
                cyc_d    = cyc_q + 16'd1;
                if (cyc_q == LastCycle) begin
                    state_d = StDone;
                    // Verdict includes this final check.
                    pass_d  = (err_d == '0);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            err_q    <= '0;
            cyc_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
            pass_q   <= pass_d;
        end
    end

`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_seen_q  <= 1'b0;
            fe_cycle_q <= '0;
            fe_data_q  <= '0;
        end else begin
            fe_seen_q  <= fe_seen_d;
            fe_cycle_q <= fe_cycle_d;
            fe_data_q  <= fe_data_d;
        end
    end

    assign first_err_cycle = fe_cycle_q;
    assign first_err_data  = fe_data_q;
`endif

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_accum_check_mon.sv
// Directed bench for accum_check_mon. A behavioural accumulator drives the
// monitor inputs; faults are injected by overriding its outputs. A second
// instance with ERR_W=2 covers error-count saturation.
module tb_accum_check_mon;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] accum_in;
    logic        accum_bypass;
    logic [31:0] accum_out;
    logic [31:0] accum_bypass_out;

    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [15:0] cycle_cnt;
    logic        busy_s, done_s, pass_s;
    logic [1:0]  err_count_s;
    logic [15:0] cycle_cnt_s;
`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
    logic [15:0] fe_cycle, fe_cycle_s;
    logic [31:0] fe_data, fe_data_s;
`endif

    // Accumulator model plus fault injection.
    logic [31:0] acc = '0;
    logic        load_en;
    logic [31:0] load_val;
    logic        force_out;
    logic [31:0] force_val;
    logic        zero_mix;

    always @(posedge clk) begin
        if (load_en) acc <= load_val;
        else         acc <= acc + accum_in;
    end

    assign accum_out        = force_out ? force_val : acc;
    assign accum_bypass_out = zero_mix ? 32'h0 : (accum_bypass ? accum_in : acc);

    accum_check_mon dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .accum_in         (accum_in),
        .accum_bypass     (accum_bypass),
        .accum_out        (accum_out),
        .accum_bypass_out (accum_bypass_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .cycle_cnt        (cycle_cnt)
`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
        ,
        .first_err_cycle  (fe_cycle),
        .first_err_data   (fe_data)
`endif
    );

    accum_check_mon #(.ERR_W(2)) dut_sat (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .accum_in         (accum_in),
        .accum_bypass     (accum_bypass),
        .accum_out        (accum_out),
        .accum_bypass_out (accum_bypass_out),
        .busy             (busy_s),
        .done             (done_s),
        .pass             (pass_s),
        .err_count        (err_count_s),
        .cycle_cnt        (cycle_cnt_s)
`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
        ,
        .first_err_cycle  (fe_cycle_s),
        .first_err_data   (fe_data_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] v);
        load_en  = 1'b1;
        load_val = v;
        step();
        load_en  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; accum_in = '0; accum_bypass = 1'b0;
        load_en = 1'b0; load_val = '0; force_out = 1'b0; force_val = '0; zero_mix = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err",  32'(err_count), 32'd0);
        check("rst_cyc",  32'(cycle_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Clean run: accumulator from 0, accum_in=1.
        accum_in = 32'd1;
        load(32'd0);
        pulse_start();
        check("clean_busy0", 32'(busy), 32'd1);
        check("clean_cyc0",  32'(cycle_cnt), 32'd0);
        repeat (15) step();
        check("clean_busy15", 32'(busy), 32'd1);
        check("clean_cyc15",  32'(cycle_cnt), 32'd15);
        step();
        check("clean_done", 32'(done), 32'd1);
        check("clean_busy", 32'(busy), 32'd0);
        check("clean_pass", 32'(pass), 32'd1);
        check("clean_err",  32'(err_count), 32'd0);
        check("clean_cyc",  32'(cycle_cnt), 32'd16);

        // Bypass path, alternating select, clean then with one corrupt cycle.
        accum_in = 32'h10;
        pulse_start();
        check("pass_cleared_on_start", 32'(pass), 32'd0);
        for (int i = 0; i < 16; i++) begin
            accum_bypass = i[0];
            step();
        end
        check("byp_done", 32'(done), 32'd1);
        check("byp_pass", 32'(pass), 32'd1);
        check("byp_err",  32'(err_count), 32'd0);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            accum_bypass = i[0];
            zero_mix     = (i == 5);
            step();
        end
        zero_mix = 1'b0;
        accum_bypass = 1'b0;
        check("bypc_done", 32'(done), 32'd1);
        check("bypc_pass", 32'(pass), 32'd0);
        check("bypc_err",  32'(err_count), 32'd1);

        // Wrap: shadow passes FFFFFFF8 -> 0 -> 8 without error.
        accum_in = 32'h8;
        load(32'hFFFF_FFF0);
        pulse_start();
        repeat (2) step();
        check("wrap_mid_acc", acc, 32'h0000_0008);
        check("wrap_mid_err", 32'(err_count), 32'd0);
        repeat (14) step();
        check("wrap_pass", 32'(pass), 32'd1);
        check("wrap_err",  32'(err_count), 32'd0);

        // Saturation: accum_out stuck at a wrong value for the whole run.
        accum_in  = 32'd1;
        force_out = 1'b1;
        force_val = 32'hDEAD_BEEF;
        pulse_start();
        repeat (16) step();
        force_out = 1'b0;
        check("sat8_err",   32'(err_count), 32'd16);
        check("sat8_pass",  32'(pass), 32'd0);
        check("sat2_done",  32'(done_s), 32'd1);
        check("sat2_err",   32'(err_count_s), 32'd3);
        check("sat2_pass",  32'(pass_s), 32'd0);
`ifdef ACCUM_CHECK_MON_FIRST_ERR_EN
        check("fe_cycle", 32'(fe_cycle), 32'd0);
        check("fe_data",  fe_data, 32'hDEAD_BEEF);
`endif

        // Reset mid-run at cycle_cnt=5, then a clean run.
        pulse_start();
        repeat (5) step();
        check("mid_cyc5", 32'(cycle_cnt), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_pass", 32'(pass), 32'd0);
        check("arst_err",  32'(err_count), 32'd0);
        check("arst_cyc",  32'(cycle_cnt), 32'd0);
        rst = 1'b0;
        step();
        check("arst_idle", 32'(busy), 32'd0);
        pulse_start();
        repeat (16) step();
        check("post_rst_pass", 32'(pass), 32'd1);

        // start while busy is ignored.
        pulse_start();
        repeat (3) step();
        check("sb_cyc3", 32'(cycle_cnt), 32'd3);
        pulse_start();
        check("sb_cyc4", 32'(cycle_cnt), 32'd4);
        step();
        check("sb_cyc5", 32'(cycle_cnt), 32'd5);
        repeat (11) step();
        check("sb_done", 32'(done), 32'd1);
        check("sb_pass", 32'(pass), 32'd1);
        check("sb_cyc",  32'(cycle_cnt), 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
